// File: rtl/pipe_skid_reg_if.sv
// Ready/valid handshake bundle for one pipeline stage boundary, plus flush and occupancy.
// The slave modport is the stage register; the master modport is whatever surrounds it.
interface pipe_skid_reg_if #(
  parameter int unsigned LANES  = 5,
  parameter int unsigned FLAG_W = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*32-1:0]   in_data;
  logic [FLAG_W-1:0]     in_flags;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*32-1:0]   out_data;
  logic [FLAG_W-1:0]     out_flags;
  logic                  flush;
  logic [1:0]            occupancy;

  modport master (
    output in_valid, in_data, in_flags, out_ready, flush,
    input  in_ready, out_valid, out_data, out_flags, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_flags, out_ready, flush,
    output in_ready, out_valid, out_data, out_flags, occupancy
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Ready/valid pipeline stage register with a one-entry skid buffer and synchronous flush.
// in_ready and out_valid come straight from the state register, so no comb path crosses the stage.
module pipe_skid_reg #(
  parameter int unsigned LANES  = 5,
  parameter int unsigned FLAG_W = 1
) (
  input logic             clk,
  input logic             reset,
  pipe_skid_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [LANES*32-1:0]   main_data_q, main_data_d;
  logic [FLAG_W-1:0]     main_flags_q, main_flags_d;
  logic [LANES*32-1:0]   skid_data_q, skid_data_d;
  logic [FLAG_W-1:0]     skid_flags_q, skid_flags_d;

  logic in_fire;
  logic out_fire;

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_data_q;
  assign bus.out_flags = main_flags_q;
  assign bus.occupancy = state_q;

  assign in_fire  = bus.in_valid  & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_flags_d = main_flags_q;
    skid_data_d  = skid_data_q;
    skid_flags_d = skid_flags_q;

    if (bus.flush) begin
      state_d      = EMPTY;
      main_data_d  = '0;
      main_flags_d = '0;
      skid_data_d  = '0;
      skid_flags_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_data_d  = bus.in_data;
            main_flags_d = bus.in_flags;
            state_d      = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_data_d  = bus.in_data;
            main_flags_d = bus.in_flags;
          end else if (in_fire) begin
            skid_data_d  = bus.in_data;
            skid_flags_d = bus.in_flags;
            state_d      = FULL;
          end else if (out_fire) begin
            // an empty main register must present a nop (all-zero instr) downstream
            main_data_d  = '0;
            main_flags_d = '0;
            state_d      = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data_d  = skid_data_q;
            main_flags_d = skid_flags_q;
            skid_data_d  = '0;
            skid_flags_d = '0;
            state_d      = BUSY;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_data_d  = '0;
          main_flags_d = '0;
          skid_data_d  = '0;
          skid_flags_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= EMPTY;
      main_data_q  <= '0;
      main_flags_q <= '0;
      skid_data_q  <= '0;
      skid_flags_q <= '0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_flags_q <= main_flags_d;
      skid_data_q  <= skid_data_d;
      skid_flags_q <= skid_flags_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector table, hand sequences for
// reset/bubble corners, then random traffic against a queue-based reference model.
module tb_pipe_skid_reg;
  localparam int unsigned LANES  = 5;
  localparam int unsigned FLAG_W = 1;
  localparam int unsigned PW     = LANES*32 + FLAG_W;

  typedef logic [PW-1:0] pay_t;

  typedef struct {
    bit          iv;
    bit          ordy;
    bit          fl;
    logic [31:0] d;
    bit          e_ov;
    bit          e_ir;
    logic [1:0]  e_occ;
    logic [31:0] e_d;
  } vec_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  pipe_skid_reg_if #(.LANES(LANES), .FLAG_W(FLAG_W)) bus ();

  pipe_skid_reg #(.LANES(LANES), .FLAG_W(FLAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lane k carries d+k and the flag is d[0]; d == 0 stands for a bubble (all zero).
  function automatic pay_t pay(logic [31:0] d);
    pay_t p;
    p = '0;
    if (d != 32'd0) begin
      for (int unsigned k = 0; k < LANES; k++) p[32*k +: 32] = d + k;
      p[PW-1 -: FLAG_W] = FLAG_W'(d[0]);
    end
    return p;
  endfunction

  task automatic chk(string name, logic [191:0] act, logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(string tag, bit ov, bit ir, logic [1:0] occ, pay_t p);
    chk({tag, ".out_valid"}, 192'(bus.out_valid), 192'(ov));
    chk({tag, ".in_ready"},  192'(bus.in_ready),  192'(ir));
    chk({tag, ".occupancy"}, 192'(bus.occupancy), 192'(occ));
    chk({tag, ".payload"},   192'({bus.out_flags, bus.out_data}), 192'(p));
  endtask

  task automatic drive(bit iv, bit ordy, bit fl, pay_t p);
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.in_data   = p[LANES*32-1:0];
    bus.in_flags  = p[PW-1 -: FLAG_W];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  pay_t model_q[$];

  initial begin
    pay_t p;
    pay_t exp_p;
    bit   iv, ordy, fl;
    bit   m_ir, m_ov;

    // Streaming, stall/skid, flush in FULL and in BUSY (input discarded).
    vecs.push_back('{1, 1, 0, 32'h24010001, 1, 1, 2'd1, 32'h24010001});
    vecs.push_back('{1, 1, 0, 32'h24010002, 1, 1, 2'd1, 32'h24010002});
    vecs.push_back('{1, 1, 0, 32'h24010003, 1, 1, 2'd1, 32'h24010003});
    vecs.push_back('{1, 1, 0, 32'h24010004, 1, 1, 2'd1, 32'h24010004});
    vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 2'd0, 32'h0});
    vecs.push_back('{1, 1, 0, 32'h8C220000, 1, 1, 2'd1, 32'h8C220000});
    vecs.push_back('{1, 0, 0, 32'h00221820, 1, 0, 2'd2, 32'h8C220000});
    vecs.push_back('{0, 0, 0, 32'h0,        1, 0, 2'd2, 32'h8C220000});
    vecs.push_back('{0, 1, 0, 32'h0,        1, 1, 2'd1, 32'h00221820});
    vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 2'd0, 32'h0});
    vecs.push_back('{1, 1, 0, 32'h8C220000, 1, 1, 2'd1, 32'h8C220000});
    vecs.push_back('{1, 0, 0, 32'h00221820, 1, 0, 2'd2, 32'h8C220000});
    vecs.push_back('{1, 0, 1, 32'h12345678, 0, 1, 2'd0, 32'h0});
    vecs.push_back('{1, 0, 0, 32'hAAAA0001, 1, 1, 2'd1, 32'hAAAA0001});
    vecs.push_back('{1, 1, 1, 32'h12345678, 0, 1, 2'd0, 32'h0});
    vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 2'd0, 32'h0});

    // Reset held, then released: idle values before the first edge.
    drive(0, 0, 0, '0);
    reset = 1'b0;
    #1;
    chk_out("reset_async", 0, 1, 2'd0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset_held", 0, 1, 2'd0, '0);
    reset = 1'b1;
    #1;
    chk_out("reset_release", 0, 1, 2'd0, '0);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, pay(vecs[i].d));
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_occ, pay(vecs[i].e_d));
    end

    // Drain to bubble: pc lane survives while held, everything zero after consumption.
    p = '0;
    p[31:0]  = 32'h8C430004;
    p[63:32] = 32'h00003004;
    drive(1, 1, 0, p);
    tick();
    chk_out("drain_held", 1, 1, 2'd1, p);
    drive(0, 1, 0, '0);
    tick();
    chk_out("drain_bubble", 0, 1, 2'd0, '0);

    // Async reset while FULL, asserted between edges.
    drive(1, 1, 0, pay(32'h11110001));
    tick();
    drive(1, 0, 0, pay(32'h22220002));
    tick();
    chk_out("pre_reset_full", 1, 0, 2'd2, pay(32'h11110001));
    drive(0, 0, 0, '0);
    #2;
    reset = 1'b0;
    #1;
    chk_out("midstream_reset", 0, 1, 2'd0, '0);
    tick();
    reset = 1'b1;
    drive(1, 1, 0, pay(32'h33330003));
    tick();
    chk_out("post_reset_accept", 1, 1, 2'd1, pay(32'h33330003));
    drive(0, 1, 0, '0);
    tick();
    chk_out("post_reset_drain", 0, 1, 2'd0, '0);

    // Random traffic against an in-order queue of held entries (capacity 2).
    model_q.delete();
    for (int n = 0; n < 500; n++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      for (int unsigned k = 0; k < LANES; k++) p[32*k +: 32] = $urandom;
      p[PW-1 -: FLAG_W] = FLAG_W'($urandom);
      drive(iv, ordy, fl, p);

      m_ov  = (model_q.size() > 0);
      m_ir  = (model_q.size() < 2);
      exp_p = m_ov ? model_q[0] : '0;
      chk_out($sformatf("rnd%0d", n), m_ov, m_ir, 2'(model_q.size()), exp_p);

      if (fl) begin
        model_q.delete();
      end else begin
        if (m_ov && ordy) void'(model_q.pop_front());
        if (m_ir && iv) model_q.push_back(p);
      end
      tick();
    end
    m_ov  = (model_q.size() > 0);
    exp_p = m_ov ? model_q[0] : '0;
    chk_out("rnd_final", m_ov, model_q.size() < 2, 2'(model_q.size()), exp_p);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
